// File: rtl/mux_nto1_pipe.sv
// mux_nto1_pipe: N-way data selector feeding a two-entry elastic buffer (head + skid).
// Optional parity tracking alongside the data is enabled by defining MUX_NTO1_PIPE_PARITY_EN.
module mux_nto1_pipe #(
  parameter int size = 32,
  parameter int ways = 4,
  localparam int sel_w = $clog2(ways)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ways*size-1:0] data_i,
  input  logic [sel_w-1:0]     select_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [size-1:0]      data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  input  logic                 flush_i,
  output logic                 sel_err_o
`ifdef MUX_NTO1_PIPE_PARITY_EN
  ,
  output logic                 parity_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [size-1:0] head_q, head_d;
  logic [size-1:0] skid_q, skid_d;
  logic            sel_err_q, sel_err_d;

  logic            accept_s;
  logic            drain_s;
  logic            sel_ok_s;
  logic [size-1:0] entry_s;
  logic            load_head_s;
  logic            load_skid_s;
  logic            move_skid_s;

  // Out-of-range indices fall through every comparison and yield zero.
  function automatic logic [size-1:0] pick_way(input logic [ways*size-1:0] d,
                                               input logic [sel_w-1:0]     s);
    logic [size-1:0] r;
    r = {size{1'b0}};
    for (int k = 0; k < ways; k++) begin
      r = (s == sel_w'(k)) ? d[k*size +: size] : r;
    end
    return r;
  endfunction

  function automatic logic even_parity(input logic [size-1:0] d);
    return ^d;
  endfunction

  assign sel_ok_s = ({1'b0, select_i} < (sel_w + 1)'(ways));
  assign entry_s  = pick_way(data_i, select_i);
  assign accept_s = valid_i & ready_o;
  assign drain_s  = valid_o & ready_i;
  assign data_o   = head_q;
  assign sel_err_o = sel_err_q;

  // Occupancy state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy; flush empties the buffer regardless of handshakes.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: state_d = accept_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (accept_s && !drain_s) begin
            state_d = ST_FULL;
          end else if (!accept_s && drain_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL:  state_d = drain_s ? ST_ONE : ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs and datapath steering, all decoded from registered state.
  always_comb begin
    ready_o     = (state_q != ST_FULL);
    valid_o     = (state_q != ST_EMPTY);
    load_head_s = 1'b0;
    load_skid_s = 1'b0;
    move_skid_s = 1'b0;
    if (flush_i) begin
      load_head_s = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: load_head_s = accept_s;
        ST_ONE: begin
          load_head_s = accept_s & drain_s;
          load_skid_s = accept_s & ~drain_s;
        end
        ST_FULL:  move_skid_s = drain_s;
        default:  load_head_s = 1'b0;
      endcase
    end
  end

  // Next values for head, skid and the sticky select error.
  always_comb begin
    head_d    = head_q;
    skid_d    = skid_q;
    sel_err_d = sel_err_q | (accept_s & ~sel_ok_s);
    if (load_head_s) begin
      head_d = entry_s;
    end else if (move_skid_s) begin
      head_d = skid_q;
    end else begin
      head_d = head_q;
    end
    if (load_skid_s) begin
      skid_d = entry_s;
    end else begin
      skid_d = skid_q;
    end
  end

  // Data and error registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head_q    <= {size{1'b0}};
      skid_q    <= {size{1'b0}};
      sel_err_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      skid_q    <= skid_d;
      sel_err_q <= sel_err_d;
    end
  end

`ifdef MUX_NTO1_PIPE_PARITY_EN
  logic head_par_q, head_par_d;
  logic skid_par_q, skid_par_d;

  // Parity bits travel with their entries through the same steering.
  always_comb begin
    head_par_d = head_par_q;
    skid_par_d = skid_par_q;
    if (load_head_s) begin
      head_par_d = even_parity(entry_s);
    end else if (move_skid_s) begin
      head_par_d = skid_par_q;
    end else begin
      head_par_d = head_par_q;
    end
    if (load_skid_s) begin
      skid_par_d = even_parity(entry_s);
    end else begin
      skid_par_d = skid_par_q;
    end
  end

  // Parity registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      head_par_q <= 1'b0;
      skid_par_q <= 1'b0;
    end else begin
      head_par_q <= head_par_d;
      skid_par_q <= skid_par_d;
    end
  end

  assign parity_o = valid_o & head_par_q;
`endif

endmodule
